// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle shared between the requesters and the round-robin arbiter.
// The master side drives the requests and the slave side (the arbiter) drives the grant outputs.
interface round_robin_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic          timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_idx,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_idx,
    output timeout
  );
endinterface

// File: rtl/round_robin_arbiter.sv
// Rotating-priority arbiter: each owner keeps the grant until it releases or
// its tenure expires, and every tenure is followed by a one-cycle dead gap.
module round_robin_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  round_robin_arbiter_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state_q,   state_d;
  logic [IW-1:0] ptr_q,     ptr_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [N-1:0]  gnt_q,     gnt_d;
  logic [IW-1:0] idx_q,     idx_d;
  logic          timeout_q, timeout_d;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int             pick_off;
  int             pick_sum;
  logic [IW-1:0]  pick_idx;

  // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    req_dbl  = {bus.req, bus.req} >> ptr_q;
    req_rot  = req_dbl[N-1:0];
    pick_off = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_off = i;
      end
    end
    pick_sum = int'(ptr_q) + pick_off;
    if (pick_sum >= N) begin
      pick_sum = pick_sum - N;
    end
    pick_idx = IW'(pick_sum);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          gnt_d   = N'(1) << pick_idx;
          idx_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        // A dropped request wins over expiry, so a same-cycle drop never flags timeout.
        if (!bus.req[idx_q] || (cnt_q == CW'(MAX_HOLD - 1))) begin
          timeout_d = bus.req[idx_q];
          state_d   = GAP;
          ptr_d     = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
          gnt_d     = '0;
          idx_d     = '0;
          cnt_d     = '0;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for the round-robin arbiter: expected tenures (owner, length, timeout)
// are queued as stimulus is driven and retired as each grant ends.
module tb_round_robin_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  typedef struct {
    int idx;
    int len;
    int to;
  } tenure_t;

  logic clk;
  logic rst_n;

  round_robin_arbiter_if #(.N(N)) bus ();

  round_robin_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  tenure_t sb[$];
  int      err_count   = 0;
  int      check_count = 0;
  bit      in_tenure   = 1'b0;
  int      cur_idx     = 0;
  int      cur_len     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] value, input int cycles);
    bus.req = value;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pushTenure(input int idx, input int len, input int to);
    tenure_t t;
    t.idx = idx;
    t.len = len;
    t.to  = to;
    sb.push_back(t);
  endtask

  task automatic applyReset(input logic [N-1:0] value);
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.req = value;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Track each tenure from the first gnt cycle to the first idle cycle, then retire it.
  always @(negedge clk) begin
    logic [3:0] inv;
    tenure_t    exp_t;
    inv[3] = $onehot0(bus.gnt);
    inv[2] = (bus.gnt_valid == (|bus.gnt));
    inv[1] = !bus.gnt_valid || bus.gnt[bus.gnt_idx];
    inv[0] = bus.gnt_valid || (bus.gnt_idx == '0);
    checkOutput("invariants", 32'(inv), 32'hF);
    if (bus.gnt_valid) begin
      if (!in_tenure) begin
        in_tenure = 1'b1;
        cur_idx   = int'(bus.gnt_idx);
        cur_len   = 1;
      end else begin
        cur_len++;
      end
      checkOutput("timeout_quiet", 32'(bus.timeout), 32'h0);
    end else if (in_tenure) begin
      in_tenure = 1'b0;
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'(cur_idx), 32'hFFFF_FFFF);
      end else begin
        exp_t = sb.pop_front();
        checkOutput("owner_idx", 32'(cur_idx), 32'(exp_t.idx));
        checkOutput("tenure_len", 32'(cur_len), 32'(exp_t.len));
        checkOutput("timeout_pulse", 32'(bus.timeout), 32'(exp_t.to));
      end
    end else begin
      checkOutput("timeout_quiet", 32'(bus.timeout), 32'h0);
    end
  end

  initial begin
    rst_n   = 1'b1;
    bus.req = '0;
    #1 rst_n = 1'b0;
    bus.req = 4'b1111;

    // Reset held with every requester active.
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("rst_gnt_valid", 32'(bus.gnt_valid), 32'h0);
    checkOutput("rst_gnt_idx", 32'(bus.gnt_idx), 32'h0);
    checkOutput("rst_timeout", 32'(bus.timeout), 32'h0);
    rst_n   = 1'b1;
    bus.req = '0;
    applyStimulus(4'b0000, 2);

    // Single requester, released after three grant cycles.
    pushTenure(2, 3, 0);
    applyStimulus(4'b0100, 1);
    checkOutput("single_gnt", 32'(bus.gnt), 32'h4);
    checkOutput("single_idx", 32'(bus.gnt_idx), 32'h2);
    applyStimulus(4'b0100, 2);
    applyStimulus(4'b0000, 1);
    checkOutput("single_release", 32'(bus.gnt), 32'h0);
    applyStimulus(4'b0000, 3);

    // Full rotation from a fresh pointer, every tenure expiring.
    applyReset(4'b0000);
    pushTenure(0, 8, 1);
    pushTenure(1, 8, 1);
    pushTenure(2, 8, 1);
    pushTenure(3, 8, 1);
    pushTenure(0, 8, 1);
    applyStimulus(4'b1111, 50);
    applyStimulus(4'b0000, 3);

    // Pointer sits past owner 1, so 0 wins over 1, then 1 follows.
    pushTenure(1, 2, 0);
    pushTenure(0, 3, 0);
    pushTenure(1, 4, 0);
    applyStimulus(4'b0010, 2);
    applyStimulus(4'b0000, 1);
    applyStimulus(4'b0011, 4);
    checkOutput("ptr_pick", 32'(bus.gnt_idx), 32'h0);
    applyStimulus(4'b0010, 6);
    applyStimulus(4'b0000, 3);

    // Owner 3 is not preempted by a new request from 0.
    pushTenure(3, 8, 1);
    pushTenure(0, 3, 0);
    applyStimulus(4'b1000, 2);
    applyStimulus(4'b1001, 4);
    checkOutput("no_preempt", 32'(bus.gnt), 32'h8);
    applyStimulus(4'b1001, 7);
    applyStimulus(4'b0000, 3);

    // Reset mid-tenure after six grant cycles drops outputs without a clock.
    pushTenure(1, 6, 0);
    applyStimulus(4'b1111, 6);
    #2 rst_n = 1'b0;
    bus.req = 4'b1010;
    #1;
    checkOutput("async_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("async_valid", 32'(bus.gnt_valid), 32'h0);
    checkOutput("async_idx", 32'(bus.gnt_idx), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pushTenure(1, 2, 0);
    applyStimulus(4'b1010, 1);
    checkOutput("post_rst_idx", 32'(bus.gnt_idx), 32'h1);
    checkOutput("post_rst_gnt", 32'(bus.gnt), 32'h2);
    applyStimulus(4'b1010, 1);
    applyStimulus(4'b0000, 4);

    // Owner drops its request on the last allowed cycle: release, not timeout.
    pushTenure(2, 8, 0);
    applyStimulus(4'b0100, 8);
    applyStimulus(4'b0000, 4);

    checkOutput("sb_drain", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end
endmodule
